vproc_result_sink: RTL and testbench

VPROC_RESULT_SINK -- requirements
Module: vproc_result_sink

---
 rtl/vproc_result_sink_pkg.sv | 18 +
 rtl/vproc_result_sink.sv | 171 +++++++++++++++++
 tb/tb_vproc_result_sink.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_result_sink_pkg.sv
// Shared definitions for the vproc result sink.
//   sink_state_e : state of the one-entry result buffer
//                  SINK_IDLE - buffer empty, any result may be accepted
//                  SINK_WB   - buffered register write waiting for a grant
//                  SINK_EXC  - buffered exception waiting for an acknowledge
package vproc_result_sink_pkg;

  typedef enum logic [1:0] {
    SINK_IDLE = 2'd0,
    SINK_WB   = 2'd1,
    SINK_EXC  = 2'd2
  } sink_state_e;

  localparam int unsigned RESULT_DATA_W = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned EXC_CODE_W    = 6;

endpackage

// File: rtl/vproc_result_sink.sv
// Result sink for offloaded coprocessor instructions.
// Tracks which instruction IDs still owe a result, accepts results through a
// one-entry buffer and forwards them either as a register-file write or as a
// synchronous exception to the core.
// Ports:
//   clk_i, async_rst_i                 clock, asynchronous active-high reset
//   issue_valid_i/issue_id_i           instruction issued, result expected
//   kill_valid_i/kill_id_i             instruction killed, no result expected
//   result_*                           result handshake from the coprocessor
//   rf_we_o/rf_waddr_o/rf_wdata_o      register write request, rf_wgnt_i grant
//   exc_valid_o/exc_id_o/exc_code_o    exception request, exc_ack_i consume
//   err_o                              sticky protocol-error flag
//   idle_o                             nothing outstanding and buffer empty
module vproc_result_sink
  import vproc_result_sink_pkg::*;
#(
  parameter int unsigned XIF_ID_W       = 3,
  parameter logic        DONT_CARE_ZERO = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  issue_valid_i,
  input  logic [XIF_ID_W-1:0]   issue_id_i,
  input  logic                  kill_valid_i,
  input  logic [XIF_ID_W-1:0]   kill_id_i,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [XIF_ID_W-1:0]   result_id_i,
  input  logic [31:0]           result_data_i,
  input  logic [4:0]            result_rd_i,
  input  logic                  result_we_i,
  input  logic                  result_exc_i,
  input  logic [5:0]            result_exccode_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  input  logic                  rf_wgnt_i,
  output logic                  exc_valid_o,
  output logic [XIF_ID_W-1:0]   exc_id_o,
  output logic [5:0]            exc_code_o,
  input  logic                  exc_ack_i,
  output logic                  err_o,
  output logic                  idle_o
);

  localparam int unsigned NUM_IDS = 1 << XIF_ID_W;

  logic [NUM_IDS-1:0]   outstanding_r;
  logic [NUM_IDS-1:0]   outstanding_next_s;
  logic                 err_r;
  logic                 err_set_s;
  sink_state_e          state_r;
  sink_state_e          state_next_s;
  logic [4:0]           buf_rd_r;
  logic [31:0]          buf_data_r;
  logic [XIF_ID_W-1:0]  buf_id_r;
  logic [5:0]           buf_code_r;
  logic                 result_accept_s;
  logic                 result_known_s;
  logic                 issue_freed_s;

  assign result_accept_s = result_valid_i & result_ready_o;
  assign result_known_s  = outstanding_r[result_id_i];

  // Outstanding-ID bookkeeping: result frees first, issue re-sets (ID reuse),
  // kill has the final word so issue+kill of one ID leaves it clear.
  always_comb begin
    outstanding_next_s = outstanding_r;
    if (result_accept_s) begin
      outstanding_next_s[result_id_i] = 1'b0;
    end else begin
      outstanding_next_s = outstanding_next_s;
    end
    if (issue_valid_i) begin
      outstanding_next_s[issue_id_i] = 1'b1;
    end else begin
      outstanding_next_s = outstanding_next_s;
    end
    if (kill_valid_i) begin
      outstanding_next_s[kill_id_i] = 1'b0;
    end else begin
      outstanding_next_s = outstanding_next_s;
    end
  end

  // An issue is legal on a busy ID only if that ID is released in the same cycle.
  assign issue_freed_s = (result_accept_s & result_known_s & (result_id_i == issue_id_i)) |
                         (kill_valid_i & (kill_id_i == issue_id_i));
  assign err_set_s = (issue_valid_i & outstanding_r[issue_id_i] & ~issue_freed_s) |
                     (result_accept_s & ~result_known_s);

  // Buffer FSM next state and the accept condition.
  always_comb begin
    state_next_s   = state_r;
    result_ready_o = 1'b0;
    case (state_r)
      SINK_IDLE: result_ready_o = 1'b1;
      SINK_WB:   result_ready_o = rf_wgnt_i;
      SINK_EXC:  result_ready_o = exc_ack_i;
      default:   result_ready_o = 1'b0;
    endcase
    if (result_ready_o) begin
      // Buffer drains this cycle; an accepted result takes its place directly.
      if (result_valid_i && result_known_s) begin
        if (result_exc_i) begin
          state_next_s = SINK_EXC;
        end else if (result_we_i && (result_rd_i != 5'd0)) begin
          state_next_s = SINK_WB;
        end else begin
          state_next_s = SINK_IDLE;
        end
      end else begin
        state_next_s = SINK_IDLE;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State, outstanding vector and sticky error flag.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_r       <= SINK_IDLE;
      outstanding_r <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      outstanding_r <= outstanding_next_s;
      err_r         <= err_r | err_set_s;
    end
  end

  // Buffer payload; only meaningful while the state says so, hence no reset.
  always_ff @(posedge clk_i) begin
    if (result_accept_s && result_known_s) begin
      buf_rd_r   <= result_rd_i;
      buf_data_r <= result_data_i;
      buf_id_r   <= result_id_i;
      buf_code_r <= result_exccode_i;
    end else begin
      buf_rd_r   <= buf_rd_r;
      buf_data_r <= buf_data_r;
      buf_id_r   <= buf_id_r;
      buf_code_r <= buf_code_r;
    end
  end

  // Output decode; payloads are don't-care while their valid is low.
  always_comb begin
    rf_we_o     = (state_r == SINK_WB);
    exc_valid_o = (state_r == SINK_EXC);
    if (rf_we_o) begin
      rf_waddr_o = buf_rd_r;
      rf_wdata_o = buf_data_r;
    end else begin
      rf_waddr_o = DONT_CARE_ZERO ? 5'd0  : {5{1'bx}};
      rf_wdata_o = DONT_CARE_ZERO ? 32'd0 : {32{1'bx}};
    end
    if (exc_valid_o) begin
      exc_id_o   = buf_id_r;
      exc_code_o = buf_code_r;
    end else begin
      exc_id_o   = DONT_CARE_ZERO ? {XIF_ID_W{1'b0}} : {XIF_ID_W{1'bx}};
      exc_code_o = DONT_CARE_ZERO ? 6'd0 : {6{1'bx}};
    end
  end

  assign err_o  = err_r;
  assign idle_o = (outstanding_r == '0) & (state_r == SINK_IDLE);

endmodule

// File: tb/tb_vproc_result_sink.sv
// Directed bench for vproc_result_sink: inputs change 1 time unit after the
// rising edge, outputs are checked in the same window.
module tb_vproc_result_sink;

  logic        clk_i = 1'b0;
  logic        async_rst_i;
  logic        issue_valid_i;
  logic [2:0]  issue_id_i;
  logic        kill_valid_i;
  logic [2:0]  kill_id_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic [2:0]  result_id_i;
  logic [31:0] result_data_i;
  logic [4:0]  result_rd_i;
  logic        result_we_i;
  logic        result_exc_i;
  logic [5:0]  result_exccode_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_wgnt_i;
  logic        exc_valid_o;
  logic [2:0]  exc_id_o;
  logic [5:0]  exc_code_o;
  logic        exc_ack_i;
  logic        err_o;
  logic        idle_o;

  int vectors  = 0;
  int miscomps = 0;

  always #5 clk_i = ~clk_i;

  vproc_result_sink #(.XIF_ID_W(3), .DONT_CARE_ZERO(1'b0)) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i),
    .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i),
    .kill_valid_i(kill_valid_i), .kill_id_i(kill_id_i),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_data_i(result_data_i),
    .result_rd_i(result_rd_i), .result_we_i(result_we_i),
    .result_exc_i(result_exc_i), .result_exccode_i(result_exccode_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_wgnt_i(rf_wgnt_i),
    .exc_valid_o(exc_valid_o), .exc_id_o(exc_id_o), .exc_code_o(exc_code_o),
    .exc_ack_i(exc_ack_i), .err_o(err_o), .idle_o(idle_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscomps++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid_i = 1'b0; issue_id_i = 3'd0;
    kill_valid_i = 1'b0;  kill_id_i = 3'd0;
    result_valid_i = 1'b0; result_id_i = 3'd0; result_data_i = 32'd0;
    result_rd_i = 5'd0; result_we_i = 1'b0; result_exc_i = 1'b0;
    result_exccode_i = 6'd0; rf_wgnt_i = 1'b0; exc_ack_i = 1'b0;
  endtask

  task automatic drive_result(input logic [2:0] id, input logic [4:0] rd,
                              input logic [31:0] data, input logic we,
                              input logic exc, input logic [5:0] code);
    result_valid_i = 1'b1; result_id_i = id; result_rd_i = rd;
    result_data_i = data; result_we_i = we; result_exc_i = exc;
    result_exccode_i = code;
  endtask

  task automatic do_reset();
    async_rst_i = 1'b1;
    #12;
    @(negedge clk_i);
    async_rst_i = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    async_rst_i = 1'b1;
    #3;
    chk("rst_ready", result_ready_o, 32'd1);
    chk("rst_rf_we", rf_we_o, 32'd0);
    chk("rst_exc_valid", exc_valid_o, 32'd0);
    chk("rst_idle", idle_o, 32'd1);
    chk("rst_err", err_o, 32'd0);
    do_reset();

    // Simple writeback with immediate grant.
    issue_valid_i = 1'b1; issue_id_i = 3'd2;
    tick();
    chk("wb_busy_idle", idle_o, 32'd0);
    issue_valid_i = 1'b0;
    drive_result(3'd2, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
    rf_wgnt_i = 1'b1;
    #1;
    chk("wb_ready_idle_state", result_ready_o, 32'd1);
    tick();
    result_valid_i = 1'b0;
    chk("wb_rf_we", rf_we_o, 32'd1);
    chk("wb_waddr", rf_waddr_o, 32'd5);
    chk("wb_wdata", rf_wdata_o, 32'hDEADBEEF);
    tick();
    chk("wb_done_rf_we", rf_we_o, 32'd0);
    chk("wb_done_idle", idle_o, 32'd1);

    // Stalled grant, second result waits and is accepted in the grant cycle.
    clear_inputs();
    issue_valid_i = 1'b1; issue_id_i = 3'd2;
    tick();
    issue_id_i = 3'd3;
    tick();
    issue_valid_i = 1'b0;
    drive_result(3'd2, 5'd7, 32'h11112222, 1'b1, 1'b0, 6'd0);
    tick();
    drive_result(3'd3, 5'd8, 32'h33334444, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rf_we", rf_we_o, 32'd1);
      chk("stall_waddr", rf_waddr_o, 32'd7);
      chk("stall_wdata", rf_wdata_o, 32'h11112222);
      chk("stall_ready", result_ready_o, 32'd0);
      tick();
    end
    rf_wgnt_i = 1'b1;
    #1;
    chk("grant_ready", result_ready_o, 32'd1);
    tick();
    result_valid_i = 1'b0;
    chk("b2b_rf_we", rf_we_o, 32'd1);
    chk("b2b_waddr", rf_waddr_o, 32'd8);
    chk("b2b_wdata", rf_wdata_o, 32'h33334444);
    tick();
    chk("b2b_done_rf_we", rf_we_o, 32'd0);
    chk("b2b_done_idle", idle_o, 32'd1);

    // Exception path: writeback suppressed, held until acknowledged.
    clear_inputs();
    issue_valid_i = 1'b1; issue_id_i = 3'd1;
    tick();
    issue_valid_i = 1'b0;
    drive_result(3'd1, 5'd9, 32'hCAFE0000, 1'b1, 1'b1, 6'd6);
    tick();
    result_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("exc_valid", exc_valid_o, 32'd1);
      chk("exc_id", exc_id_o, 32'd1);
      chk("exc_code", exc_code_o, 32'd6);
      chk("exc_no_rf_we", rf_we_o, 32'd0);
      chk("exc_ready", result_ready_o, 32'd0);
      tick();
    end
    exc_ack_i = 1'b1;
    #1;
    chk("exc_ack_ready", result_ready_o, 32'd1);
    tick();
    exc_ack_i = 1'b0;
    chk("exc_done_valid", exc_valid_o, 32'd0);
    chk("exc_done_rf_we", rf_we_o, 32'd0);
    chk("exc_done_idle", idle_o, 32'd1);

    // ID reuse: issue and result of the same ID in one cycle.
    clear_inputs();
    issue_valid_i = 1'b1; issue_id_i = 3'd3;
    tick();
    drive_result(3'd3, 5'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    tick();
    clear_inputs();
    chk("reuse_err", err_o, 32'd0);
    chk("reuse_idle", idle_o, 32'd0);
    kill_valid_i = 1'b1; kill_id_i = 3'd3;
    tick();
    kill_valid_i = 1'b0;
    chk("kill_idle", idle_o, 32'd1);
    // Issue and kill of one ID in the same cycle leaves it clear.
    issue_valid_i = 1'b1; issue_id_i = 3'd5;
    kill_valid_i = 1'b1; kill_id_i = 3'd5;
    tick();
    clear_inputs();
    chk("issue_kill_idle", idle_o, 32'd1);
    chk("issue_kill_err", err_o, 32'd0);

    // Result for an ID that was never issued: dropped, sticky error.
    drive_result(3'd4, 5'd4, 32'h0BADF00D, 1'b1, 1'b0, 6'd0);
    tick();
    result_valid_i = 1'b0;
    chk("unknown_err", err_o, 32'd1);
    chk("unknown_rf_we", rf_we_o, 32'd0);
    chk("unknown_exc", exc_valid_o, 32'd0);
    tick();
    chk("unknown_err_sticky", err_o, 32'd1);

    // Reset in the middle of a pending writeback.
    do_reset();
    chk("rst_clears_err", err_o, 32'd0);
    issue_valid_i = 1'b1; issue_id_i = 3'd6;
    tick();
    issue_valid_i = 1'b0;
    drive_result(3'd6, 5'd3, 32'h12345678, 1'b1, 1'b0, 6'd0);
    tick();
    result_valid_i = 1'b0;
    chk("midrst_pre_rf_we", rf_we_o, 32'd1);
    async_rst_i = 1'b1;
    #1;
    chk("midrst_rf_we", rf_we_o, 32'd0);
    chk("midrst_ready", result_ready_o, 32'd1);
    #1;
    async_rst_i = 1'b0;
    tick();
    chk("midrst_idle", idle_o, 32'd1);
    chk("midrst_rf_we_after", rf_we_o, 32'd0);

    // Duplicate issue of an outstanding ID raises the error flag.
    issue_valid_i = 1'b1; issue_id_i = 3'd0;
    tick();
    chk("dup_first_err", err_o, 32'd0);
    tick();
    issue_valid_i = 1'b0;
    chk("dup_err", err_o, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule
